// File: rtl/rr_arb8_idx.sv
// rr_arb8_idx: 8-requester round-robin arbiter with a registered binary grant index.
// A grant is held until the owner acks, drops its request, or the hold limit expires.
// At least one idle cycle always separates two grants (break-before-make downstream).
module rr_arb8_idx #(
  parameter int unsigned TIMEOUT = 16  // max grant hold in cycles; 0 disables expiry
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] req_i,
  input  logic       ack_i,
  output logic       gnt_valid_o,
  output logic [2:0] gnt_idx_o,
  output logic       timeout_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  logic [2:0]  winner;
  logic        found;
  logic [2:0]  cand;
  logic        own_req;
  logic        expire;
  logic        rel;

  // Rotating priority scan: first set request starting at ptr_q and wrapping.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Release conditions for the current owner; ack takes priority over expiry.
  always_comb begin
    own_req = req_i[idx_q];
    expire  = (TIMEOUT != 0) && (cnt_q == TimeoutLast);
    rel     = ack_i || !own_req || expire;
  end

  // State register and all output-driving flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          idx_d   = winner;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (rel) begin
          state_d = StIdle;
          // Served channel becomes lowest priority for the next scan.
          ptr_d   = idx_q + 3'd1;
          tmo_d   = expire && !ack_i && own_req;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs come straight from flops; no input-to-output combinational path.
  always_comb begin
    gnt_valid_o = (state_q == StGrant);
    gnt_idx_o   = idx_q;
    timeout_o   = tmo_q;
  end

endmodule

// File: tb/tb_rr_arb8_idx.sv
// Self-checking bench for rr_arb8_idx: directed scenarios plus randomized traffic,
// compared against a grant-level behavioural model.
module tb_rr_arb8_idx;

  localparam int TO = 4;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] req_i;
  logic       ack_i;
  logic       gnt_valid_o;
  logic [2:0] gnt_idx_o;
  logic       timeout_o;

  int n_checks;
  int n_errors;

  // Behavioural model: who owns the bus, how long it has held it, next start point.
  int m_busy, m_owner, m_ptr, m_held, m_tmo;

  rr_arb8_idx #(.TIMEOUT(TO)) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .ack_i       (ack_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o),
    .timeout_o   (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_tmo   = 0;
  endtask

  // One clock edge worth of model behaviour, given the inputs sampled at that edge.
  task automatic model_update(input logic [7:0] r, input logic a);
    int c;
    bit expire;
    m_tmo = 0;
    if (m_busy == 0) begin
      for (int i = 0; i < 8; i++) begin
        c = (m_ptr + i) % 8;
        if (r[c]) begin
          m_owner = c;
          m_busy  = 1;
          m_held  = 1;
          break;
        end
      end
    end else begin
      expire = (TO != 0) && (m_held == TO);
      if (a || !r[m_owner] || expire) begin
        m_tmo  = (!a && r[m_owner] && expire) ? 1 : 0;
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 8;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic ack_at(input int n);
    return (m_busy != 0) && (m_held == n);
  endfunction

  task automatic step(input logic [7:0] r, input logic a);
    req_i = r;
    ack_i = a;
    @(posedge clk_i);
    model_update(r, a);
    #1;
    check_eq("model_valid", 32'(gnt_valid_o), 32'(m_busy));
    check_eq("model_idx", 32'(gnt_idx_o), 32'(m_owner));
    check_eq("model_timeout", 32'(timeout_o), 32'(m_tmo));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    ack_i  = 1'b0;
    model_reset();
    #12;
    check_eq("rst_valid", 32'(gnt_valid_o), 32'd0);
    check_eq("rst_idx", 32'(gnt_idx_o), 32'd0);
    check_eq("rst_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    logic       a;
    bit         v2 [9];
    int         i2 [9];
    bit         v4 [6];
    bit         t4 [6];
    n_checks = 0;
    n_errors = 0;

    // Idle with no requests.
    do_reset();
    for (int k = 0; k < 10; k++) step(8'h00, 1'b0);

    // Two requesters, ack on the third grant cycle: 2, idle, 5, idle, 2.
    v2 = '{1, 1, 1, 0, 1, 1, 1, 0, 1};
    i2 = '{2, 2, 2, 2, 5, 5, 5, 5, 2};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(8'h24, ack_at(3));
      check_eq("rot2_valid", 32'(gnt_valid_o), 32'(v2[k]));
      check_eq("rot2_idx", 32'(gnt_idx_o), 32'(i2[k]));
    end

    // All requesting with immediate acks: 0..7,0 with one idle cycle between.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      step(8'hFF, ack_at(1));
      check_eq("ff_valid", 32'(gnt_valid_o), (k % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("ff_idx", 32'(gnt_idx_o), 32'((k / 2) % 8));
    end

    // Hold-time expiry: 4 grant cycles, timeout pulse, then regrant of channel 0.
    v4 = '{1, 1, 1, 1, 0, 1};
    t4 = '{0, 0, 0, 0, 1, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(8'h01, 1'b0);
      check_eq("tmo_valid", 32'(gnt_valid_o), 32'(v4[k]));
      check_eq("tmo_pulse", 32'(timeout_o), 32'(t4[k]));
      check_eq("tmo_idx", 32'(gnt_idx_o), 32'd0);
    end

    // Owner drops its request mid-grant.
    do_reset();
    step(8'h08, 1'b0);
    check_eq("drop_grant", 32'(gnt_idx_o), 32'd3);
    step(8'h08, 1'b0);
    step(8'h00, 1'b0);
    check_eq("drop_valid", 32'(gnt_valid_o), 32'd0);
    check_eq("drop_timeout", 32'(timeout_o), 32'd0);

    // Ack coinciding with expiry is a normal release.
    for (int k = 0; k < 5; k++) begin
      step(8'h08, ack_at(TO));
      check_eq("ackexp_valid", 32'(gnt_valid_o), (k < 4) ? 32'd1 : 32'd0);
      check_eq("ackexp_timeout", 32'(timeout_o), 32'd0);
    end

    // Reset mid-grant drops valid asynchronously and clears the pointer.
    do_reset();
    step(8'h40, 1'b0);
    check_eq("mid_grant_idx", 32'(gnt_idx_o), 32'd6);
    step(8'h40, 1'b0);
    #1;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_eq("async_valid", 32'(gnt_valid_o), 32'd0);
    check_eq("async_idx", 32'(gnt_idx_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(8'h41, 1'b0);
    check_eq("post_rst_valid", 32'(gnt_valid_o), 32'd1);
    check_eq("post_rst_idx", 32'(gnt_idx_o), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    r = 8'h00;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      else if ($urandom_range(0, 7) == 0) r = r & ~(8'd1 << $urandom_range(0, 7));
      a = ($urandom_range(0, 4) == 0);
      step(r, a);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
